smpwm_bridge: RTL

- Downstream consumer of the delayed-difference stage: accepts 16-bit sign-magnitude samples (magnitude plus sign bit, 1 = negative).
- Converts each sample into a fixed-period H-bridge PWM pair: pwm_p drives the positive leg, pwm_n the negative leg.
- Inserts dead-time whenever the drive direction reverses.
- Buffers one sample; reports underrun when no new sample is available at a period boundary.

---
 rtl/anspwm_pkg.sv | 22 ++
 rtl/pwm_period_cnt.sv | 18 +
 rtl/smpwm_bridge.sv | 112 +++++++++++
 3 files changed

// File: rtl/anspwm_pkg.sv
// Shared types for the sign-magnitude PWM path: FSM states, drive directions
// and the sign-magnitude sample record used by the delayed-difference stage.
package anspwm_pkg;

  localparam int SM_WIDTH = 16;

  typedef enum logic [2:0] {IDLE, DEAD, DRIVE_P, DRIVE_N, OFF} pwm_state_t;

  typedef enum logic [1:0] {NONE, POS, NEG} pwm_dir_t;

  typedef struct packed {
    logic                sign;
    logic [SM_WIDTH-1:0] mag;
  } sm_sample_t;

  // A zero duty has no direction, whatever its sign bit says.
  function automatic pwm_dir_t dir_of(input logic sign, input logic nonzero);
    if (!nonzero) return NONE;
    return sign ? NEG : POS;
  endfunction

endpackage

// File: rtl/pwm_period_cnt.sv
// Free-running PWM period counter; boundary marks the clock where cnt is zero.
module pwm_period_cnt #(
  parameter int PB = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [PB-1:0] cnt,
  output logic          boundary
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + 1'b1;
  end

  assign boundary = (cnt == '0);

endmodule

// File: rtl/smpwm_bridge.sv
// Sign-magnitude sample to H-bridge PWM pair, with one-sample buffering,
// dead-time on direction reversal and sticky underrun reporting.
module smpwm_bridge
  import anspwm_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int PB       = 10,
  parameter int DEADTIME = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_mag,
  input  logic             in_sign,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             pwm_p,
  output logic             pwm_n,
  output logic             period_start,
  output logic             underrun
);

  logic [PB-1:0] cnt;
  logic          boundary;
  logic          accept;
  logic          hold_full, hold_sign, act_sign, src_sign;
  logic [PB-1:0] hold_duty, act_duty, src_duty, eff_duty;
  pwm_dir_t      src_dir, act_dir, last_dir;
  pwm_state_t    state, state_eff;
  logic          unused_mag_lsbs;

  pwm_period_cnt #(.PB(PB)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .cnt      (cnt),
    .boundary (boundary)
  );

  assign in_ready        = !hold_full;
  assign accept          = in_valid && in_ready;
  assign unused_mag_lsbs = ^in_mag[WIDTH-PB-1:0];

  // state_eff is the state that owns the current clock, so the boundary clock
  // already drives with the freshly loaded sample.
  always_comb begin
    src_sign  = hold_full ? hold_sign : act_sign;
    src_duty  = hold_full ? hold_duty : act_duty;
    src_dir   = dir_of(src_sign, |src_duty);
    act_dir   = dir_of(act_sign, |act_duty);
    state_eff = state;
    eff_duty  = act_duty;
    if (boundary) begin
      eff_duty = src_duty;
      if (state == IDLE && !hold_full)                 state_eff = IDLE;
      else if (src_dir == NONE)                        state_eff = OFF;
      else if (last_dir != NONE && last_dir != src_dir) state_eff = DEAD;
      else                                             state_eff = (src_dir == NEG) ? DRIVE_N : DRIVE_P;
    end else if (state == DEAD && cnt == PB'(DEADTIME)) begin
      state_eff = (act_dir == NEG) ? DRIVE_N : DRIVE_P;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_dir <= NONE;
    end else begin
      state <= state_eff;
      if (state_eff == DRIVE_P)      last_dir <= POS;
      else if (state_eff == DRIVE_N) last_dir <= NEG;
    end
  end

  // A same-clock accept wins over the boundary clear, keeping the hold full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_sign <= 1'b0;
      hold_duty <= '0;
      act_sign  <= 1'b0;
      act_duty  <= '0;
      underrun  <= 1'b0;
    end else begin
      if (boundary && hold_full) begin
        act_sign <= hold_sign;
        act_duty <= hold_duty;
      end
      if (boundary && !hold_full && state != IDLE) underrun <= 1'b1;
      if (accept) begin
        hold_full <= 1'b1;
        hold_sign <= in_sign;
        hold_duty <= in_mag[WIDTH-1 -: PB];
      end else if (boundary) begin
        hold_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_p        <= 1'b0;
      pwm_n        <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pwm_p        <= (state_eff == DRIVE_P) && (cnt < eff_duty);
      pwm_n        <= (state_eff == DRIVE_N) && (cnt < eff_duty);
      period_start <= boundary;
    end
  end

  a_no_shoot_through: assert property (@(posedge clk) disable iff (!rst_n) !(pwm_p && pwm_n));

endmodule
